multicycle_control_fsm: RTL and testbench

//  Multicycle MIPS main control unit and successor to the single-cycle opcode decoder.
//  A Moore FSM sequences FETCH/DECODE/EXEC/MEM/WB per instruction over a shared memory.
//  It supports R-format, lw, sw, beq, bne, j and addi, with a mem_ready handshake and a

---
 rtl/multicycle_control_fsm.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared memory with a mem_ready handshake and wait timeout. Optional macro: CTRL_ILLEGAL_TRAP_EN.
module multicycle_control_fsm #(
  parameter int ALU_OP_W = 2,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                zero_inv,
  output logic [1:0]          pc_src,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                instr_done,
  output logic                bus_err,
  output logic                illegal
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC,
    S_R_WB, S_ADDI_EX, S_ADDI_WB, S_BRANCH, S_JUMP, S_HALT, S_TRAP
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic       r_bus_err;
  logic       r_is_sw;
  logic       r_is_bne;
  logic       w_wait_state;
  logic       w_timeout;

  logic       w_pc_write, w_pc_write_cond, w_zero_inv, w_i_or_d, w_mem_read;
  logic       w_mem_write, w_ir_write, w_reg_dst, w_mem_to_reg, w_reg_write;
  logic       w_alu_src_a, w_instr_done;
  logic [1:0] w_pc_src, w_alu_src_b, w_alu_op;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // mem_ready arriving on the limit cycle wins over the timeout
  assign w_timeout    = w_wait_state && !mem_ready && (r_wait_cnt == WAIT_LIM);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   w_next = S_MEM_ADDR;
          OP_R:           w_next = S_EXEC;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:           w_next = S_JUMP;
          OP_ADDI:        w_next = S_ADDI_EX;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:        w_next = S_TRAP;
`else
          default:        w_next = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: w_next = r_is_sw ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
      S_EXEC:     w_next = S_R_WB;
      S_R_WB:     w_next = S_FETCH;
      S_ADDI_EX:  w_next = S_ADDI_WB;
      S_ADDI_WB:  w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
    if (w_timeout) w_next = S_HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= 8'd0;
      r_bus_err  <= 1'b0;
      r_is_sw    <= 1'b0;
      r_is_bne   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait_cnt <= 8'd0;
      else if (w_wait_state && !mem_ready)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_timeout)
        r_bus_err <= 1'b1;
      // IR is stable after fetch; latch what later states need from it
      if (r_state == S_DECODE) begin
        r_is_sw  <= (opcode == OP_SW);
        r_is_bne <= opcode[0];
      end
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_illegal <= 1'b0;
    else if (w_next == S_TRAP)
      r_illegal <= 1'b1;
  end
  assign illegal = r_illegal & rst_n;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_zero_inv      = 1'b0;
    w_pc_src        = 2'b00;
    w_i_or_d        = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_dst       = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = ALU_ADD;
    w_instr_done    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = mem_ready;
        w_pc_write  = mem_ready;
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
`ifndef CTRL_ILLEGAL_TRAP_EN
        w_instr_done = !(opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI});
`endif
      end
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_write  = 1'b1;
        w_i_or_d     = 1'b1;
        w_instr_done = mem_ready;
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = ALU_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_src        = 2'b01;
        w_zero_inv      = r_is_bne;
        w_instr_done    = 1'b1;
      end
      S_JUMP: begin
        w_pc_write   = 1'b1;
        w_pc_src     = 2'b10;
        w_instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are forced low combinationally so a reset cuts any in-flight write at once
  assign pc_write      = w_pc_write & rst_n;
  assign pc_write_cond = w_pc_write_cond & rst_n;
  assign zero_inv      = w_zero_inv & rst_n;
  assign pc_src        = w_pc_src & {2{rst_n}};
  assign i_or_d        = w_i_or_d & rst_n;
  assign mem_read      = w_mem_read & rst_n;
  assign mem_write     = w_mem_write & rst_n;
  assign ir_write      = w_ir_write & rst_n;
  assign reg_dst       = w_reg_dst & rst_n;
  assign mem_to_reg    = w_mem_to_reg & rst_n;
  assign reg_write     = w_reg_write & rst_n;
  assign alu_src_a     = w_alu_src_a & rst_n;
  assign alu_src_b     = w_alu_src_b & {2{rst_n}};
  assign alu_op        = rst_n ? ALU_OP_W'(w_alu_op) : '0;
  assign instr_done    = w_instr_done & rst_n;
  assign bus_err       = r_bus_err & rst_n;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (WAIT_MAX=3); expected cycle counts are queued
// per instruction and popped when instr_done is seen.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, zero_inv, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, bus_err, illegal;
  logic [1:0] pc_src, alu_src_b, alu_op;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  // per-instruction observations
  int         c_cycles, c_mem_read, c_mem_write, c_ir_write, c_bus_err;
  logic       l_reg_write, l_mem_to_reg, l_reg_dst, l_pc_write, l_pwc, l_zinv;
  logic [1:0] l_pc_src, l_alu_op, p_alu_op;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.ALU_OP_W(2), .WAIT_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .zero_inv(zero_inv),
    .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .instr_done(instr_done), .bus_err(bus_err), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at posedge+1 with the FSM in FETCH; low_mask bit i holds mem_ready low in cycle i+1.
  task automatic run_instr(input logic [5:0] op, input logic [31:0] low_mask,
                           input int exp_cycles, input string tag);
    int  cyc;
    bit  done;
    int  exp;
    exp_q.push_back(exp_cycles);
    opcode = op;
    cyc = 0; done = 0;
    c_mem_read = 0; c_mem_write = 0; c_ir_write = 0; c_bus_err = 0;
    p_alu_op = 2'b00; l_alu_op = 2'b00;
    while (!done && cyc < 30) begin
      mem_ready = !low_mask[cyc];
      @(negedge clk);
      cyc++;
      c_mem_read  += int'(mem_read);
      c_mem_write += int'(mem_write);
      c_ir_write  += int'(ir_write);
      c_bus_err   += int'(bus_err);
      p_alu_op     = l_alu_op;
      l_alu_op     = alu_op;
      if (instr_done === 1'b1) begin
        done         = 1;
        l_reg_write  = reg_write;
        l_mem_to_reg = mem_to_reg;
        l_reg_dst    = reg_dst;
        l_pc_write   = pc_write;
        l_pwc        = pc_write_cond;
        l_pc_src     = pc_src;
        l_zinv       = zero_inv;
        exp = exp_q.pop_front();
        chk({tag, "_cycles"}, 32'(cyc), 32'(exp));
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      chk({tag, "_done_timeout"}, 32'(done), 32'd1);
      void'(exp_q.pop_front());
    end
    c_cycles = cyc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_alu_src_b", 32'(alu_src_b), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_instr(6'h23, 32'h0, 5, "lw");
    chk("lw_reg_write", 32'(l_reg_write), 1);
    chk("lw_mem_to_reg", 32'(l_mem_to_reg), 1);
    chk("lw_mem_read_cycles", 32'(c_mem_read), 2);

    run_instr(6'h2B, 32'h38, 7, "sw_wait");
    chk("sw_mem_write_cycles", 32'(c_mem_write), 4);
    chk("sw_bus_err", 32'(c_bus_err), 0);
    chk("sw_reg_write", 32'(l_reg_write), 0);

    run_instr(6'h00, 32'h0, 4, "rtype");
    chk("r_reg_dst", 32'(l_reg_dst), 1);
    chk("r_reg_write", 32'(l_reg_write), 1);
    chk("r_exec_alu_op", 32'(p_alu_op), 2);

    run_instr(6'h08, 32'h0, 4, "addi");
    chk("addi_reg_write", 32'(l_reg_write), 1);
    chk("addi_reg_dst", 32'(l_reg_dst), 0);

    run_instr(6'h04, 32'h0, 3, "beq");
    chk("beq_pwc", 32'(l_pwc), 1);
    chk("beq_pc_src", 32'(l_pc_src), 1);
    chk("beq_zero_inv", 32'(l_zinv), 0);
    chk("beq_alu_op", 32'(l_alu_op), 1);

    run_instr(6'h05, 32'h0, 3, "bne");
    chk("bne_pwc", 32'(l_pwc), 1);
    chk("bne_pc_src", 32'(l_pc_src), 1);
    chk("bne_zero_inv", 32'(l_zinv), 1);

    run_instr(6'h02, 32'h0, 3, "j");
    chk("j_pc_write", 32'(l_pc_write), 1);
    chk("j_pc_src", 32'(l_pc_src), 2);

    // three low cycles in FETCH then ready on the limit cycle: no error
    run_instr(6'h23, 32'h7, 8, "lw_fetch_wait");
    chk("fetch_wait_bus_err", 32'(c_bus_err), 0);
    chk("fetch_wait_ir_write", 32'(c_ir_write), 1);

`ifdef CTRL_ILLEGAL_TRAP_EN
    opcode = 6'h3F; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("trap_illegal", 32'(illegal), 1);
    chk("trap_mem_read", 32'(mem_read), 0);
    chk("trap_done", 32'(instr_done), 0);
    @(posedge clk);
    do_reset();
    chk("trap_clr_illegal", 32'(illegal), 0);
`else
    run_instr(6'h3F, 32'h0, 2, "nop");
    chk("nop_illegal", 32'(illegal), 0);
    run_instr(6'h02, 32'h0, 3, "j_after_nop");
`endif

    opcode = 6'h2B; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    chk("rstwr_mem_write_before", 32'(mem_write), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstwr_mem_write_async", 32'(mem_write), 0);
    chk("rstwr_mem_read_async", 32'(mem_read), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rstwr_fetch_mem_read", 32'(mem_read), 1);
    chk("rstwr_fetch_mem_write", 32'(mem_write), 0);

    repeat (3) @(negedge clk);
    chk("tmo_before_bus_err", 32'(bus_err), 0);
    @(negedge clk);
    chk("tmo_bus_err", 32'(bus_err), 1);
    chk("tmo_halt_mem_read", 32'(mem_read), 0);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("halt_sticky_bus_err", 32'(bus_err), 1);
    chk("halt_ir_write", 32'(ir_write), 0);
    chk("halt_mem_read", 32'(mem_read), 0);
    @(posedge clk);
    do_reset();
    @(negedge clk);
    chk("post_rst_bus_err", 32'(bus_err), 0);
    chk("post_rst_mem_read", 32'(mem_read), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
